// File: rtl/btb_tag_ctrl.sv
// Tag SRAM sequencer for the BTB: clears the array after reset/flush, then shares the single
// RW port between fetch lookups and a 2-deep update FIFO, with forwarding from queued updates.
module btb_tag_ctrl #(
   parameter int IDX_W = 8,
   parameter int TAG_W = 21
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   output logic             init_done,
   input  logic             lk_valid,
   output logic             lk_ready,
   input  logic [IDX_W-1:0] lk_idx,
   input  logic [TAG_W-1:0] lk_tag,
   output logic             lk_resp_valid,
   output logic             lk_hit,
   input  logic             up_valid,
   output logic             up_ready,
   input  logic [IDX_W-1:0] up_idx,
   input  logic [TAG_W-1:0] up_tag,
   input  logic             up_inval,
   output logic             sram_csb,
   output logic             sram_web,
   output logic [IDX_W-1:0] sram_addr,
   output logic [TAG_W:0]   sram_din,
   input  logic [TAG_W:0]   sram_dout
);

   typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [TAG_W:0]   data;
   } upd_t;

   state_t           state;
   logic [IDX_W-1:0] init_cnt;
   upd_t             fifo [2];
   logic             rd_ptr, wr_ptr;
   logic [1:0]       cnt;

   logic             resp_q, fwd_q;
   logic [TAG_W:0]   fwd_data_q;
   logic [TAG_W-1:0] lk_tag_q;

   logic             run, full, lk_acc, pop, push;
   upd_t             head, tail, push_ent;
   logic             fwd_nxt;
   logic [TAG_W:0]   fwd_data_nxt;
   logic [TAG_W:0]   word;

   assign run       = (state == RUN);
   assign full      = (cnt == 2'd2);
   assign head      = fifo[rd_ptr];
   assign tail      = fifo[~rd_ptr];
   assign init_done = run;

   // A full FIFO takes the port for one cycle, which bounds lookup starvation to one cycle.
   assign lk_ready  = run & ~full;
   assign lk_acc    = lk_valid & lk_ready;
   assign pop       = run & (full | (~lk_valid & (cnt != 2'd0)));
   assign up_ready  = run & ~full;
   assign push      = up_valid & up_ready;

   assign push_ent.idx  = up_idx;
   assign push_ent.data = up_inval ? '0 : {1'b1, up_tag};

   always_comb begin
      sram_csb  = 1'b1;
      sram_web  = 1'b1;
      sram_addr = '0;
      sram_din  = '0;
      if (state == INIT) begin
         sram_csb  = 1'b0;
         sram_web  = 1'b0;
         sram_addr = init_cnt;
      end else if (pop) begin
         sram_csb  = 1'b0;
         sram_web  = 1'b0;
         sram_addr = head.idx;
         sram_din  = head.data;
      end else if (lk_acc) begin
         sram_csb  = 1'b0;
         sram_addr = lk_idx;
      end
   end

   // Tail is the younger entry and never drains, so it overrides a head match.
   always_comb begin
      fwd_nxt      = 1'b0;
      fwd_data_nxt = '0;
      if ((cnt != 2'd0) && !pop && (head.idx == lk_idx)) begin
         fwd_nxt      = 1'b1;
         fwd_data_nxt = head.data;
      end
      if (full && (tail.idx == lk_idx)) begin
         fwd_nxt      = 1'b1;
         fwd_data_nxt = tail.data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         init_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               state    <= INIT;
               init_cnt <= '0;
            end
            INIT: begin
               if (flush) begin
                  init_cnt <= '0;
               end else if (init_cnt == {IDX_W{1'b1}}) begin
                  state    <= RUN;
                  init_cnt <= '0;
               end else begin
                  init_cnt <= init_cnt + 1'b1;
               end
            end
            RUN: begin
               if (flush) begin
                  state    <= INIT;
                  init_cnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) fifo[i] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         cnt    <= '0;
      end else if (flush && (state != IDLE)) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         cnt    <= '0;
      end else begin
         if (push) begin
            fifo[wr_ptr] <= push_ent;
            wr_ptr       <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         cnt <= cnt + {1'b0, push} - {1'b0, pop};
      end
   end

   // Response stage survives flush; only reset drops it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_q     <= 1'b0;
         fwd_q      <= 1'b0;
         fwd_data_q <= '0;
         lk_tag_q   <= '0;
      end else begin
         resp_q <= lk_acc;
         if (lk_acc) begin
            fwd_q      <= fwd_nxt;
            fwd_data_q <= fwd_data_nxt;
            lk_tag_q   <= lk_tag;
         end
      end
   end

   assign word          = fwd_q ? fwd_data_q : sram_dout;
   assign lk_resp_valid = resp_q;
   assign lk_hit        = resp_q & word[TAG_W] & (word[TAG_W-1:0] == lk_tag_q);

endmodule

// File: tb/tb_btb_tag_ctrl.sv
// Randomized and directed bench for btb_tag_ctrl against an architectural tag-array model.
module tb_btb_tag_ctrl;

   logic        clk, rst_n, flush;
   logic        init_done, lk_valid, lk_ready, lk_resp_valid, lk_hit;
   logic [7:0]  lk_idx, up_idx, sram_addr;
   logic [20:0] lk_tag, up_tag;
   logic        up_valid, up_ready, up_inval, sram_csb, sram_web;
   logic [21:0] sram_din, sram_dout;

   btb_tag_ctrl dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .init_done(init_done),
      .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_idx(lk_idx), .lk_tag(lk_tag),
      .lk_resp_valid(lk_resp_valid), .lk_hit(lk_hit),
      .up_valid(up_valid), .up_ready(up_ready), .up_idx(up_idx), .up_tag(up_tag),
      .up_inval(up_inval), .sram_csb(sram_csb), .sram_web(sram_web),
      .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [21:0] mem [256];
   always @(posedge clk) begin
      if (!sram_csb) begin
         if (!sram_web) mem[sram_addr] <= sram_din;
         else           sram_dout      <= mem[sram_addr];
      end
   end

   int n_chk, n_err;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic [7:0]  idx;
      logic [21:0] data;
   } ent_t;

   // Model: arch[] is the tag array as seen after every accepted update, in order.
   logic [21:0] arch [256];
   ent_t        q [$];
   int          phase;        // 0 idle, 1 init, 2 run
   logic [7:0]  init_addr;
   bit          resp_pend, resp_exp;
   int          starve;

   task automatic clear_arch();
      for (int i = 0; i < 256; i++) arch[i] = '0;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_outs"}, {init_done, lk_ready, up_ready, lk_resp_valid, lk_hit, sram_csb, sram_web},
          7'b0000011);
      chk({tag, "_addr_din"}, {sram_addr, sram_din}, 30'h0);
   endtask

   task automatic step();
      int   sz;
      bit   drain, acc;
      ent_t e;
      @(negedge clk);
      if (!rst_n) begin
         chk_reset_outs("rst");
         phase = 0; q.delete(); resp_pend = 0; starve = 0; clear_arch();
      end else begin
         chk("resp_vld", lk_resp_valid, resp_pend);
         if (resp_pend) chk("lk_hit", lk_hit, resp_exp);
         chk("init_done", init_done, phase == 2);
         chk("up_ready", up_ready, (phase == 2) && (q.size() < 2));
         resp_pend = 0;
         if (phase == 0) begin
            chk("idle_csb", sram_csb, 1'b1);
         end else if (phase == 1) begin
            chk("init_cmd", {sram_csb, sram_web, sram_addr, sram_din}, {2'b00, init_addr, 22'h0});
            chk("init_lk_ready", lk_ready, 1'b0);
         end else begin
            sz    = q.size();
            drain = (sz == 2) || (!lk_valid && sz > 0);
            acc   = lk_valid && (sz < 2);
            if (lk_valid) chk("lk_ready", lk_ready, sz < 2);
            if (drain) chk("drain_cmd", {sram_csb, sram_web, sram_addr, sram_din},
                           {2'b00, q[0].idx, q[0].data});
            else if (acc) chk("read_cmd", {sram_csb, sram_web, sram_addr}, {2'b01, lk_idx});
            else chk("nop_csb", sram_csb, 1'b1);
            if (lk_valid && !lk_ready) starve++; else starve = 0;
            chk("starve", starve > 1, 1'b0);
            if (acc) begin
               resp_pend = 1;
               resp_exp  = arch[lk_idx][21] && (arch[lk_idx][20:0] == lk_tag);
            end
            if (drain) void'(q.pop_front());
            if (up_valid && sz < 2) begin
               e.idx  = up_idx;
               e.data = up_inval ? 22'h0 : {1'b1, up_tag};
               q.push_back(e);
               arch[up_idx] = e.data;
            end
         end
         if (phase != 0 && flush) begin
            q.delete(); clear_arch(); phase = 1; init_addr = 0; starve = 0;
         end else if (phase == 0) begin
            phase = 1; init_addr = 0;
         end else if (phase == 1) begin
            if (init_addr == 8'hff) phase = 2;
            else init_addr = init_addr + 8'd1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      lk_valid = 0; up_valid = 0; up_inval = 0; flush = 0;
   endtask

   task automatic lkup(input logic [7:0] i, input logic [20:0] t);
      lk_valid = 1; lk_idx = i; lk_tag = t;
      step();
      lk_valid = 0;
   endtask

   initial begin
      n_chk = 0; n_err = 0; phase = 0; init_addr = 0; resp_pend = 0; resp_exp = 0; starve = 0;
      sram_dout = '0;
      for (int i = 0; i < 256; i++) mem[i] = 22'($urandom);
      clear_arch();
      rst_n = 0; idle_in(); lk_idx = 0; lk_tag = 0; up_idx = 0; up_tag = 0;
      repeat (3) step();
      rst_n = 1;

      // Reset release: IDLE + 256 clear writes, then a miss on a cleared entry.
      repeat (257) step();
      chk("run_after_init", init_done, 1'b1);
      lkup(8'd5, 21'h0);
      step();

      // Update then lookup.
      up_valid = 1; up_idx = 8'h12; up_tag = 21'h1ABCD; step(); up_valid = 0;
      repeat (2) step();
      lkup(8'h12, 21'h1ABCD);
      lkup(8'h12, 21'h1ABCE);
      step();

      // Forwarding while lookups hold the port.
      lk_valid = 1; lk_idx = 8'h40; lk_tag = 0;
      up_valid = 1; up_idx = 8'd3; up_tag = 21'd7; step(); up_valid = 0;
      lk_idx = 8'd3; lk_tag = 21'd7; step();
      up_valid = 1; up_inval = 1; step(); up_valid = 0; up_inval = 0;
      step();
      lk_valid = 0; repeat (4) step();

      // FIFO full under continuous lookups.
      lk_valid = 1; lk_idx = 8'h50; lk_tag = 0;
      up_valid = 1; up_idx = 8'h60; up_tag = 21'h11; step();
      up_idx = 8'h61; up_tag = 21'h22; step(); up_valid = 0;
      chk("full_up_ready", up_ready, 1'b0);
      chk("full_lk_ready", lk_ready, 1'b0);
      repeat (4) step();
      lk_idx = 8'h60; lk_tag = 21'h11; step();
      lk_valid = 0; step();

      // Flush wipes installed entries.
      flush = 1; step(); flush = 0;
      repeat (257) step();
      lkup(8'h12, 21'h1ABCD);
      lkup(8'h60, 21'h11);
      step();

      // Random traffic over a small index/tag space for collisions.
      for (int c = 0; c < 3000; c++) begin
         lk_valid = ($urandom_range(0, 3) != 0);
         lk_idx   = 8'($urandom_range(0, 7));
         lk_tag   = 21'($urandom_range(0, 3));
         up_valid = ($urandom_range(0, 2) == 0);
         up_idx   = 8'($urandom_range(0, 7));
         up_tag   = 21'($urandom_range(0, 3));
         up_inval = ($urandom_range(0, 5) == 0);
         flush    = ($urandom_range(0, 599) == 0);
         step();
      end
      idle_in();
      repeat (300) step();

      // Async reset mid-INIT at address 100.
      flush = 1; step(); flush = 0;
      for (int c = 0; c < 300 && !(phase == 1 && init_addr == 8'd100); c++) step();
      chk("reached_init100", {phase == 1, init_addr}, {1'b1, 8'd100});
      rst_n = 0;
      #1;
      chk_reset_outs("async_rst");
      repeat (2) step();
      rst_n = 1;
      repeat (258) step();
      lkup(8'd3, 21'd7);
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
